// File: rtl/mips_bus_pkg.sv
// Shared definitions for the data-bus timer: register offsets, CTRL layout, MODE codes, FSM states.
// Pure declarations; no logic.
package mips_bus_pkg;

  localparam logic [1:0] CTRL_OFS   = 2'b00;
  localparam logic [1:0] PRESET_OFS = 2'b01;
  localparam logic [1:0] COUNT_OFS  = 2'b10;
  localparam logic [1:0] PRESC_OFS  = 2'b11;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  localparam int PRESC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } timer_state_t;

  // Field order mirrors the CTRL bit layout so the struct reads back as-is.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_regs.sv
// Timer register window: address decode, CTRL/PRESET(/PRESCALE) storage, read mux, irq pending flag.
// Reads are combinational; writes land on the clock edge. PRESCALE exists only with TIMER_PRESCALE_EN.
module timer_regs
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          COUNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  input  logic               we,
  input  logic               re,
  input  logic [COUNT_W-1:0] count,
  input  logic               pend_set,
  input  logic               en_clr,
  output ctrl_t              ctrl,
  output logic [COUNT_W-1:0] preset,
`ifdef TIMER_PRESCALE_EN
  output logic [PRESC_W-1:0] prescale,
`endif
  output logic [31:0]        rdata,
  output logic               hit,
  output logic               irq
);

  logic       irq_pend;
  logic [1:0] ofs;
  logic       wr_ctrl;
  logic       wr_preset;
  logic       unused_addr_lsb;

  assign hit       = addr[31:4] == BASE_ADDR[31:4];
  assign ofs       = addr[3:2];
  assign wr_ctrl   = hit && we && (ofs == CTRL_OFS);
  assign wr_preset = hit && we && (ofs == PRESET_OFS);
  assign irq       = irq_pend & ctrl.im;
  assign unused_addr_lsb = ^addr[1:0];

  // A CPU write to CTRL outranks the FSM's end-of-run EN clear; a pending set outranks a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      preset   <= '0;
      irq_pend <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= '{im: wdata[CTRL_IM], mode: wdata[CTRL_MODE_HI:CTRL_MODE_LO], en: wdata[CTRL_EN]};
      else if (en_clr)
        ctrl.en <= 1'b0;
      if (wr_preset)
        preset <= wdata[COUNT_W-1:0];
      if (pend_set)
        irq_pend <= 1'b1;
      else if (wr_ctrl || wr_preset)
        irq_pend <= 1'b0;
    end
  end

`ifdef TIMER_PRESCALE_EN
  always_ff @(posedge clk) begin
    if (reset)
      prescale <= '0;
    else if (hit && we && (ofs == PRESC_OFS))
      prescale <= wdata[PRESC_W-1:0];
  end
`endif

  always_comb begin
    rdata = '0;
    if (hit && re) begin
      case (ofs)
        CTRL_OFS:   rdata = {28'b0, ctrl};
        PRESET_OFS: rdata = 32'(preset);
        COUNT_OFS:  rdata = 32'(count);
`ifdef TIMER_PRESCALE_EN
        PRESC_OFS:  rdata = 32'(prescale);
`else
        PRESC_OFS:  rdata = '0;
`endif
      endcase
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: IDLE -> LOAD -> CNT -> INT, one-shot or auto-reload, masked irq.
// Optional clock prescaler on the count phase under TIMER_PRESCALE_EN.
module timer_dev
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          COUNT_W   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  timer_state_t       state;
  ctrl_t              ctrl;
  logic [COUNT_W-1:0] preset;
  logic [COUNT_W-1:0] count;
  logic               tick;
  logic               at_end;
  logic               pend_set;
  logic               en_clr;

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] prescale;
  logic [PRESC_W-1:0] div;

  assign tick = (div == prescale);

  always_ff @(posedge clk) begin
    if (reset)
      div <= '0;
    else if (state == LOAD)
      div <= '0;
    else if (state == CNT)
      div <= tick ? '0 : div + 1'b1;
  end
`else
  assign tick = 1'b1;
`endif

  // COUNT <= 1 rather than == 1 so a zero PRESET still expires after one step without wrapping.
  assign at_end   = (count <= COUNT_W'(1));
  assign pend_set = (state == CNT) && ctrl.en && tick && at_end;
  assign en_clr   = (state == INT) && !((ctrl.mode == MODE_RELOAD) && ctrl.en);

  timer_regs #(
    .BASE_ADDR (BASE_ADDR),
    .COUNT_W   (COUNT_W)
  ) u_regs (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .count    (count),
    .pend_set (pend_set),
    .en_clr   (en_clr),
    .ctrl     (ctrl),
    .preset   (preset),
`ifdef TIMER_PRESCALE_EN
    .prescale (prescale),
`endif
    .rdata    (rdata),
    .hit      (hit),
    .irq      (irq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (ctrl.en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl.en) begin
            state <= IDLE;
          end else if (tick) begin
            if (at_end) begin
              count <= '0;
              state <= INT;
            end else begin
              count <= count - COUNT_W'(1);
            end
          end
        end
        INT: state <= ((ctrl.mode == MODE_RELOAD) && ctrl.en) ? LOAD : IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed plus random bus traffic against timer_dev, checked each cycle against a run-length reference model.
module tb_timer_dev;

  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_EXP = 3;

  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [31:0] addr, wdata, rdata;
  logic        hit, irq;

  int n_chk = 0, n_fail = 0, n_edges = 0;

  // Reference model: a run is described by its latched length and elapsed steps.
  int          m_phase;
  logic        m_en, m_im, m_pend;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_cnt, m_n;
  logic [15:0] m_ps;
  int          m_t;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .hit   (hit),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic in_win(input logic [31:0] a);
    return a[31:4] == 28'h00007F0;
  endfunction

  function automatic logic [31:0] model_rdata();
    logic [31:0] v;
    v = '0;
    if (re && in_win(addr)) begin
      case (addr[3:2])
        2'd0: v = {28'b0, m_im, m_mode, m_en};
        2'd1: v = m_preset;
        2'd2: v = m_cnt;
`ifdef TIMER_PRESCALE_EN
        default: v = {16'b0, m_ps};
`else
        default: v = '0;
`endif
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_en = 0; m_im = 0; m_pend = 0; m_mode = 0;
    m_preset = 0; m_cnt = 0; m_n = 0; m_ps = 0; m_t = 0;
  endtask

  task automatic model_edge();
    logic wr_c, wr_p, set_p, clr_en;
    int   nxt, lim;
    if (reset) begin
      model_reset();
      return;
    end
    wr_c = we && in_win(addr) && addr[3:2] == 2'd0;
    wr_p = we && in_win(addr) && addr[3:2] == 2'd1;
    set_p = 0; clr_en = 0; nxt = m_phase;
    case (m_phase)
      P_IDLE: if (m_en) nxt = P_LOAD;
      P_LOAD: begin m_n = m_preset; m_t = 0; m_cnt = m_preset; nxt = P_RUN; end
      P_RUN: begin
        if (!m_en) nxt = P_IDLE;
        else begin
          m_t++;
          lim = ((m_n == 0) ? 1 : int'(m_n)) * (int'(m_ps) + 1);
          if (m_t >= lim) begin m_cnt = 0; set_p = 1; nxt = P_EXP; end
          else m_cnt = m_n - 32'(m_t / (int'(m_ps) + 1));
        end
      end
      default: begin
        if (m_mode == 2'b01 && m_en) nxt = P_LOAD;
        else begin clr_en = 1; nxt = P_IDLE; end
      end
    endcase
    if (wr_c) begin m_en = wdata[0]; m_mode = wdata[2:1]; m_im = wdata[3]; end
    else if (clr_en) m_en = 0;
    if (wr_p) m_preset = wdata;
    if (set_p) m_pend = 1;
    else if (wr_c || wr_p) m_pend = 0;
`ifdef TIMER_PRESCALE_EN
    if (we && in_win(addr) && addr[3:2] == 2'd3) m_ps = wdata[15:0];
`endif
    m_phase = nxt;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, check combinational view against the model, clock, advance the model.
  task automatic cyc(input logic r, input logic w, input logic rd_en, input logic [31:0] a, input logic [31:0] d);
    reset = r; we = w; re = rd_en; addr = a; wdata = d;
    #2;
    chk("hit", 32'(hit), 32'(in_win(a)));
    chk("rdata", rdata, model_rdata());
    chk("irq", 32'(irq), 32'(m_pend & m_im));
    @(posedge clk);
    model_edge();
    n_edges++;
    #1;
  endtask

  task automatic wr(input logic [3:0] o, input logic [31:0] d);
    cyc(1'b0, 1'b1, 1'b0, BASE + {28'b0, o}, d);
  endtask

  task automatic rd(input logic [3:0] o);
    cyc(1'b0, 1'b0, 1'b1, BASE + {28'b0, o}, 32'h0);
  endtask

  task automatic peek(input logic [31:0] a);
    reset = 0; we = 0; re = 1; addr = a;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int   ents[$];
    int   prev, first;
    logic found;

    reset = 1; we = 0; re = 0; addr = 0; wdata = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    // Reset state and window decode
    for (int o = 0; o < 4; o++) begin
      peek(BASE + 32'(o * 4));
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_hit", 32'(hit), 32'd1);
    end
    peek(BASE + 32'h10);
    chk("win_hit_out", 32'(hit), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);

    // One-shot, N=5, masked irq enabled
    wr(4'h4, 32'd5);
    wr(4'h0, 32'h9);
    for (int i = 1; i <= 8; i++) begin
      rd(4'h8);
      if (i >= 2 && i <= 6) chk("os_count", rdata, 32'(7 - i));
      chk("os_irq", 32'(irq), 32'(i >= 7));
    end
    peek(BASE);
    chk("os_ctrl_after", rdata, 32'h8);
    wr(4'h0, 32'h8);
    chk("os_irq_clear", 32'(irq), 32'd0);

    // Auto-reload periods, then a shorter PRESET mid-run
    do_reset();
    wr(4'h4, 32'd3);
    wr(4'h0, 32'hB);
    prev = 0;
    for (int i = 0; i < 24; i++) begin
      rd(4'h8);
      if (prev == 1 && rdata == 0) ents.push_back(n_edges);
      prev = int'(rdata);
    end
    chk("ar_entries", 32'(ents.size() >= 3), 32'd1);
    if (ents.size() >= 3) begin
      chk("ar_period_a", 32'(ents[1] - ents[0]), 32'd5);
      chk("ar_period_b", 32'(ents[2] - ents[1]), 32'd5);
    end
    wr(4'h4, 32'd1);
    peek(BASE + 32'h8);
    if (prev == 1 && rdata == 0) ents.push_back(n_edges);
    prev = int'(rdata);
    for (int i = 0; i < 20; i++) begin
      rd(4'h8);
      if (prev == 1 && rdata == 0) ents.push_back(n_edges);
      prev = int'(rdata);
    end
    chk("ar_short_period", 32'(ents[$] - ents[$-1]), 32'd3);

    // Freeze on EN clear, restart from PRESET
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h1);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      rd(4'h8);
      if (rdata == 32'd7) found = 1;
    end
    chk("frz_reach", 32'(found), 32'd1);
    wr(4'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      rd(4'h8);
      chk("frz_hold", rdata, 32'd6);
    end
    wr(4'h0, 32'h1);
    rd(4'h8);
    chk("reen_loadcyc", rdata, 32'd6);
    rd(4'h8);
    chk("reen_reload", rdata, 32'd10);

    // CTRL write coinciding with INT entry, then with the INT-cycle EN clear
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h9);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      rd(4'h8);
      if (rdata == 32'd1) found = 1;
    end
    chk("coin_reach", 32'(found), 32'd1);
    wr(4'h0, 32'h9);
    chk("set_wins", 32'(irq), 32'd1);
    wr(4'h0, 32'h1);
    peek(BASE);
    chk("ctrl_wins_en", rdata, 32'h1);
    chk("ctrl_clr_irq", 32'(irq), 32'd0);
    rd(4'h8);
    rd(4'h8);
    cyc(1'b1, 1'b1, 1'b0, BASE + 32'h4, 32'h55);
    for (int o = 0; o < 4; o++) begin
      peek(BASE + 32'(o * 4));
      chk("rst_over_wr", rdata, 32'h0);
    end
    chk("rst_over_irq", 32'(irq), 32'd0);

`ifdef TIMER_PRESCALE_EN
    wr(4'hC, 32'd2);
    wr(4'h4, 32'd4);
    wr(4'h0, 32'h9);
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      rd(4'h8);
      if (irq && first < 0) first = i;
    end
    chk("presc_period", 32'(first), 32'd14);
    peek(BASE + 32'hC);
    chk("presc_readback", rdata, 32'd2);
`else
    first = 0;
    wr(4'hC, 32'd2);
    peek(BASE + 32'hC);
    chk("presc_absent", rdata, 32'(first));
`endif

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      logic        r, w, rd_en;
      logic [1:0]  o;
      logic [31:0] a, d;
      r = ($urandom_range(63) == 0);
      w = ($urandom_range(3) == 0);
      rd_en = 1'($urandom_range(1));
      o = 2'($urandom_range(3));
      a = BASE + {28'b0, o, 2'($urandom_range(3))};
      if ($urandom_range(7) == 0) a = $urandom;
      case (o)
        2'd0: begin d = 32'($urandom_range(15)); d[0] = ($urandom_range(3) != 0); end
        2'd1: d = 32'($urandom_range(6));
        default: d = $urandom;
      endcase
`ifdef TIMER_PRESCALE_EN
      if (o == 2'd3) w = 0;
`endif
      cyc(r, w, rd_en, a, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped programmable countdown timer on the CPU data bus. It is the responder to the load/store accesses driven by the datapath (ALU address, register-B write data, MemWrite/MemRead).
- The top-level decodes `hit` to choose between `dm` read data and `rdata`.
- `irq` goes to a future exception unit.

Parameters:
- BASE_ADDR, 32'h0000_7F00, 16-byte aligned base of the register window; addr[31:4] is compared against BASE_ADDR[31:4].
- COUNT_W, 32, width of PRESET/COUNT (≤32); upper rdata bits read 0.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- addr  in  32  byte address from ALU result
- wdata  in  32  store data
- we  in  1  store strobe (MemWrite)
- re  in  1  load strobe (MemRead)
- rdata  out  32  load data, combinational
- hit  out  1  addr falls inside the 16-byte window, combinational
- irq  out  1  interrupt request, registered pending flag AND mask

Behaviour:
- Register map, selected by addr[3:2]; addr[1:0] are ignored and all accesses are whole-word:
  - 0x0 CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), bit3 IM (irq mask); other bits read 0.
  - 0x4 PRESET: R/W.
  - 0x8 COUNT: read-only; writes are ignored.
  - 0xC: reads 0; see Optional Feature.
- Reset values: CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE. Consequently irq=0 and rdata=0.
- Reads: rdata = selected register when hit&re, else 0. No read side effects.
- Writes: take effect at the clock edge where hit&we.
- Write priority:
  - A CPU write to CTRL wins over the FSM clearing EN in the same cycle.
  - A write to PRESET never alters COUNT directly; the new value is used at the next LOAD.
- irq_pend:
  - Set on entry to INT.
  - Cleared by any write to CTRL or PRESET.
  - If set and clear coincide, set wins.
  - irq = irq_pend & CTRL.IM.
- FSM (one transition per cycle):
  - IDLE: if EN, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - if !EN, go to IDLE and COUNT holds its value;
    - else if COUNT ≤ 1, COUNT <= 0, set irq_pend, go to INT;
    - else COUNT <= COUNT-1.
  - INT:
    - MODE=01 and EN: go to LOAD.
    - Otherwise: EN <= 0 (unless the CPU writes CTRL that cycle) and go to IDLE. COUNT stays 0.
- Timing, taking the edge that writes EN=1 as edge 0 and PRESET=N:
  - Edge 1: LOAD.
  - Edge 2: COUNT=N.
  - Edge N+2 (N≥1): COUNT=0, INT, irq_pend=1.
  - Edge 3 for N=0.
  - Auto-reload period: N+2 cycles between successive irq_pend set events.
- Clearing EN mid-count freezes COUNT. Re-enabling restarts from LOAD, i.e. from PRESET; there is no resume.
- Reset asserted in any state returns all registers to their reset values at that edge, overriding a simultaneous bus write.
- No wrap-around: COUNT never decrements below 0.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- With the macro defined:
  - 0xC is the PRESCALE register (16-bit R/W, reset 0); rdata carries the value in bits [15:0].
  - A divider counter loads 0 in LOAD state and advances only in CNT.
  - COUNT decrements, or the CNT exit is taken, only on cycles where divider==PRESCALE; the divider resets to 0 on those cycles.
  - Period becomes N*(PRESCALE+1)+2.
- Without the macro: 0xC reads 0, writes to 0xC are ignored, and no divider logic exists.

Decomposition:
- Shared package (mips_bus_pkg) holds:
  - register offsets CTRL_OFS=2'b00, PRESET_OFS=2'b01, COUNT_OFS=2'b10, PRESC_OFS=2'b11;
  - CTRL bit indices;
  - MODE encodings;
  - FSM state encoding (IDLE, LOAD, CNT, INT).
- One natural sub-module: timer_regs (address decode, register file, rdata mux, irq_pend). The FSM and counter stay in timer_dev.

Test Plan:
- Reset then read all four offsets with re=1 → rdata=0 each; irq=0; hit=1 for 0x7F00–0x7F0C, hit=0 for 0x7F10.
- PRESET=5, CTRL=0x9 (EN, one-shot, IM) → COUNT reads 5,4,3,2,1 on edges 2..6; irq=1 from edge 7; CTRL reads 0x8 afterwards; write CTRL=0x8 → irq=0 next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM) → irq_pend sets every 5 cycles; mid-run write PRESET=1 → the following period is 3 cycles.
- PRESET=10, enable, clear EN when COUNT=6 → state IDLE, COUNT frozen at 6; re-enable → COUNT reloads 10.
- Write CTRL=0x1 in the same cycle the FSM enters INT → EN stays 1, irq_pend stays 1 (set wins); assert reset during CNT with we=1 to PRESET → all registers 0 next cycle.
- With TIMER_PRESCALE_EN: PRESCALE=2, PRESET=4 → irq_pend after 4*3+2=14 cycles; without the macro, a write of 0x2 to 0xC reads back 0.
